// File: rtl/weight_stream_pkg.sv
// Shared definitions for the weight-line stream between the weight store and
// weight_bram_controller.
// Contents:
//   - base parameters of the weight layout (beat width, channels, element width,
//     kernel side, source memory depth)
//   - derived widths: KERNEL_SET_WIDTH, BRAM_LINE_WIDTH, BEATS_PER_LINE, ADDR_W
//   - FSM state encoding of the streamer
//   - next_line_addr(): line address increment with wrap at BRAM_DEPTH
package weight_stream_pkg;

  localparam int AXIS_DATA_WIDTH = 64;
  localparam int NUM_CHANNELS    = 8;
  localparam int DATA_WIDTH      = 8;
  localparam int FILTER_SIZE     = 3;
  localparam int BRAM_DEPTH      = 512;

  // One kernel set holds every channel of one FILTER_SIZE x FILTER_SIZE kernel.
  // A memory line carries set A in the low half and set B in the high half.
  localparam int KERNEL_SET_WIDTH = NUM_CHANNELS * DATA_WIDTH * FILTER_SIZE * FILTER_SIZE;
  localparam int BRAM_LINE_WIDTH  = 2 * KERNEL_SET_WIDTH;
  localparam int BEATS_PER_LINE   = BRAM_LINE_WIDTH / AXIS_DATA_WIDTH;
  localparam int ADDR_W           = $clog2(BRAM_DEPTH);
  localparam int BEAT_CNT_W       = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } stream_state_t;

  // Explicit wrap so the depth does not have to be a power of two.
  function automatic logic [ADDR_W-1:0] next_line_addr(input logic [ADDR_W-1:0] addr);
    if (addr == ADDR_W'(BRAM_DEPTH - 1)) begin
      return '0;
    end
    return addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/axis_line_serializer.sv
// Turns one memory line into BEATS_PER_LINE AXI-Stream beats, lowest beat first.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_load          load i_line into the send buffer (only when o_ready)
//   i_line          full memory line
//   o_ready         buffer can take a new line on this edge (empty, or the
//                   last beat is being accepted right now)
//   o_last_hs       the last beat of the current line is handshaking this cycle
//   m_axis_tvalid   beat valid
//   m_axis_tready   downstream ready
//   m_axis_tdata    current beat
//   m_axis_tlast    high on the last beat of each line
module axis_line_serializer
  import weight_stream_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_load,
  input  logic [BRAM_LINE_WIDTH-1:0] i_line,
  output logic                       o_ready,
  output logic                       o_last_hs,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tlast
);

  logic [BRAM_LINE_WIDTH-1:0] r_line;
  logic [BEAT_CNT_W-1:0]      r_beat;
  logic                       r_valid;
  logic                       r_last;
  logic                       w_hs;

  assign w_hs      = r_valid && m_axis_tready;
  assign o_last_hs = w_hs && r_last;
  assign o_ready   = !r_valid || o_last_hs;

  // The line is kept as a shift register so tdata comes straight from flops:
  // each accepted beat shifts the next one down into the low bits. tlast is
  // precomputed one beat ahead instead of being decoded from the counter.
  // A load wins over the shift so a new line can follow the last beat with
  // no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line  <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_line  <= i_line;
      r_beat  <= '0;
      r_valid <= 1'b1;
      r_last  <= (BEATS_PER_LINE == 1);
    end else if (w_hs) begin
      if (r_last) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_beat  <= '0;
      end else begin
        r_line <= r_line >> AXIS_DATA_WIDTH;
        r_beat <= r_beat + BEAT_CNT_W'(1);
        r_last <= (r_beat == BEAT_CNT_W'(BEATS_PER_LINE - 2));
      end
    end
  end

  assign m_axis_tvalid = r_valid;
  assign m_axis_tdata  = r_line[AXIS_DATA_WIDTH-1:0];
  assign m_axis_tlast  = r_last;

endmodule

// File: rtl/weight_axis_streamer.sv
// AXI-Stream master for the weight-line stream. Reads i_num_lines consecutive
// lines starting at i_base_addr (wrapping at BRAM_DEPTH) and sends each one as
// BEATS_PER_LINE beats, with tlast on every line's last beat. The next line is
// prefetched while the current one streams, so back-to-back lines need no gap.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_start         start pulse, sampled only while idle
//   i_base_addr     first line address
//   i_num_lines     number of lines, 0..BRAM_DEPTH
//   o_busy          high from accepted start until o_done
//   o_done          one-cycle pulse at end of transfer
//   o_mem_rd_en     one-cycle read strobe per line
//   o_mem_rd_addr   read address
//   i_mem_rd_data   line data, valid the cycle after o_mem_rd_en
//   m_axis_*        AXI-Stream master (tvalid, tready, tdata, tlast)
module weight_axis_streamer
  import weight_stream_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [ADDR_W-1:0]          i_base_addr,
  input  logic [ADDR_W:0]            i_num_lines,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_mem_rd_en,
  output logic [ADDR_W-1:0]          o_mem_rd_addr,
  input  logic [BRAM_LINE_WIDTH-1:0] i_mem_rd_data,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tlast
);

  stream_state_t              r_state;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_rd_en;
  logic                       r_rd_vld;
  logic [ADDR_W-1:0]          r_rd_addr;
  logic [ADDR_W:0]            r_to_read;
  logic [ADDR_W:0]            r_to_send;
  logic [BRAM_LINE_WIDTH-1:0] r_pf_line;
  logic                       r_pf_valid;

  logic                       w_ser_ready;
  logic                       w_last_hs;
  logic                       w_load;
  logic                       w_load_from_pf;
  logic                       w_load_from_mem;
  logic [BRAM_LINE_WIDTH-1:0] w_load_line;

  // Choose what feeds the send buffer. The prefetch buffer always holds the
  // older line, so it goes first; otherwise memory data that is arriving
  // right now is loaded directly (always the case for the first line).
  always_comb begin
    w_load_from_pf  = 1'b0;
    w_load_from_mem = 1'b0;
    if ((r_state == ST_FETCH || r_state == ST_STREAM) && w_ser_ready) begin
      if (r_pf_valid) begin
        w_load_from_pf = 1'b1;
      end else if (r_rd_vld) begin
        w_load_from_mem = 1'b1;
      end
    end
    w_load      = w_load_from_pf || w_load_from_mem;
    w_load_line = r_pf_valid ? r_pf_line : i_mem_rd_data;
  end

  // Control FSM. r_rd_vld marks the cycle in which i_mem_rd_data holds the
  // line requested by the previous read strobe. A read is only issued when
  // the prefetch buffer is empty and no read is in flight, so there is at
  // most one outstanding read and its data always has somewhere to go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_addr  <= '0;
      r_to_read  <= '0;
      r_to_send  <= '0;
      r_pf_line  <= '0;
      r_pf_valid <= 1'b0;
    end else begin
      r_rd_en  <= 1'b0;
      r_rd_vld <= r_rd_en;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_num_lines != '0) begin
              r_busy     <= 1'b1;
              r_rd_en    <= 1'b1;
              r_rd_addr  <= i_base_addr;
              r_to_read  <= i_num_lines - (ADDR_W+1)'(1);
              r_to_send  <= i_num_lines;
              r_pf_valid <= 1'b0;
              r_state    <= ST_FETCH;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_FETCH: begin
          if (w_load) begin
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (r_to_read != '0 && !r_pf_valid && !r_rd_en && !r_rd_vld) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= next_line_addr(r_rd_addr);
            r_to_read <= r_to_read - (ADDR_W+1)'(1);
          end
          if (w_load_from_pf) begin
            r_pf_valid <= 1'b0;
          end
          if (r_rd_vld && !w_load_from_mem) begin
            r_pf_line  <= i_mem_rd_data;
            r_pf_valid <= 1'b1;
          end
          if (w_last_hs) begin
            r_to_send <= r_to_send - (ADDR_W+1)'(1);
            if (r_to_send == (ADDR_W+1)'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  axis_line_serializer u_serializer (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_line        (w_load_line),
    .o_ready       (w_ser_ready),
    .o_last_hs     (w_last_hs),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
  );

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_mem_rd_en   = r_rd_en;
  assign o_mem_rd_addr = r_rd_addr;

endmodule

// File: tb/tb_weight_axis_streamer.sv
// Bench for weight_axis_streamer: a 1-cycle-latency line memory whose line k
// beat b holds {k, b}, a scoreboard of expected beats, and one task per scenario.
module tb_weight_axis_streamer;
  import weight_stream_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       i_start;
  logic [ADDR_W-1:0]          i_base_addr;
  logic [ADDR_W:0]            i_num_lines;
  logic                       o_busy;
  logic                       o_done;
  logic                       o_mem_rd_en;
  logic [ADDR_W-1:0]          o_mem_rd_addr;
  logic [BRAM_LINE_WIDTH-1:0] memRdData = '0;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata;
  logic                       m_axis_tlast;

  logic [ADDR_W-1:0]          rdQ[$];
  logic [AXIS_DATA_WIDTH:0]   expQ[$];
  logic [AXIS_DATA_WIDTH:0]   obsQ[$];

  int   nChecks = 0;
  int   nFails  = 0;
  int   doneCycle;
  int   firstValidCycle;
  int   gapCycles;
  int   stallCycles;
  int   stallErrs;
  bit   doneSeen;
  logic busyAtOne;
  logic busyAtDone;
  logic validAtDone;

  always #5 clk = ~clk;

  weight_axis_streamer dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_base_addr   (i_base_addr),
    .i_num_lines   (i_num_lines),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_rd_addr (o_mem_rd_addr),
    .i_mem_rd_data (memRdData),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
  );

  // Memory contents are computed on the fly: beat b of line k is {k, b}.
  function automatic logic [BRAM_LINE_WIDTH-1:0] lineData(input int addr);
    logic [BRAM_LINE_WIDTH-1:0] d;
    d = '0;
    for (int b = 0; b < BEATS_PER_LINE; b++) begin
      d[b*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = {32'(addr), 32'(b)};
    end
    return d;
  endfunction

  // Memory model with one cycle of read latency; every read address is logged.
  always @(posedge clk) begin
    if (o_mem_rd_en) begin
      memRdData <= lineData(int'(o_mem_rd_addr));
      rdQ.push_back(o_mem_rd_addr);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Expected beats of n lines starting at base, in transmit order.
  task automatic pushExpected(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < BEATS_PER_LINE; b++) begin
        expQ.push_back({1'(b == BEATS_PER_LINE - 1), 32'((base + k) % BRAM_DEPTH), 32'(b)});
      end
    end
  endtask

  task automatic applyStimulus(input int base, input int n);
    @(negedge clk);
    rdQ.delete();
    obsQ.delete();
    i_base_addr = ADDR_W'(base);
    i_num_lines = (ADDR_W+1)'(n);
    i_start     = 1'b1;
  endtask

  // Runs cycles until o_done (or the budget runs out), driving tready per mode
  // and logging accepted beats. Mode 0: always ready. Mode 1: ready toggles,
  // with a 10-cycle stall. Mode 3: always ready, plus a new start request and
  // new base/count while busy.
  task automatic drain(input int mode, input int maxCycles);
    int                         cyc;
    bit                         prevStall;
    bit                         seenValid;
    logic [AXIS_DATA_WIDTH-1:0] prevData;
    logic                       prevLast;
    cyc = 0; prevStall = 0; seenValid = 0; prevData = '0; prevLast = 1'b0;
    doneSeen = 0; doneCycle = -1; firstValidCycle = -1; gapCycles = 0;
    stallCycles = 0; stallErrs = 0; busyAtOne = 1'b0; busyAtDone = 1'b1; validAtDone = 1'b1;
    while (!doneSeen && cyc < maxCycles) begin
      @(negedge clk);
      cyc++;
      i_start = (mode == 3 && cyc == 5);
      if (mode == 3 && cyc == 5) begin
        i_base_addr = ADDR_W'(100);
        i_num_lines = (ADDR_W+1)'(3);
      end
      if (mode == 1) begin
        m_axis_tready = (cyc >= 30 && cyc < 40) ? 1'b0 : 1'(cyc % 2);
      end else begin
        m_axis_tready = 1'b1;
      end
      if (cyc == 1) busyAtOne = o_busy;
      if (prevStall && (!m_axis_tvalid || m_axis_tdata !== prevData || m_axis_tlast !== prevLast)) begin
        stallErrs++;
      end
      if (m_axis_tvalid && m_axis_tready) obsQ.push_back({m_axis_tlast, m_axis_tdata});
      if (m_axis_tvalid && !m_axis_tready) stallCycles++;
      if (m_axis_tvalid && !seenValid) begin
        seenValid = 1;
        firstValidCycle = cyc;
      end
      if (o_done) begin
        doneSeen = 1;
        doneCycle = cyc;
        busyAtDone = o_busy;
        validAtDone = m_axis_tvalid;
      end else if (seenValid && !m_axis_tvalid) begin
        gapCycles++;
      end
      prevStall = m_axis_tvalid && !m_axis_tready;
      prevData  = m_axis_tdata;
      prevLast  = m_axis_tlast;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nChecks++;
    if ({o_busy, o_done, o_mem_rd_en, o_mem_rd_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b rd=%b tvalid=%b expected all 0", o_busy, o_done, o_mem_rd_en, m_axis_tvalid);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    nChecks++;
    if ({o_busy, o_done, o_mem_rd_en, m_axis_tvalid} !== 4'b0) begin
      nFails++;
      $display("[TB] FAIL idle_outputs: got busy=%b done=%b rd=%b tvalid=%b expected all 0", o_busy, o_done, o_mem_rd_en, m_axis_tvalid);
    end
  endtask

  task automatic test_single_line();
    int                       nExp;
    logic [AXIS_DATA_WIDTH:0] expBeat;
    logic [AXIS_DATA_WIDTH:0] gotBeat;
    pushExpected(0, 1);
    applyStimulus(0, 1);
    drain(0, 200);
    nExp = expQ.size();
    nChecks++;
    if (obsQ.size() != nExp) begin
      nFails++; $display("[TB] FAIL single_beat_count: got %0d expected %0d", obsQ.size(), nExp);
    end
    for (int i = 0; i < nExp; i++) begin
      expBeat = expQ.pop_front();
      gotBeat = (i < obsQ.size()) ? obsQ[i] : 'x;
      nChecks++;
      if (gotBeat !== expBeat) begin
        nFails++; $display("[TB] FAIL single_beat%0d: got %h expected %h", i, gotBeat, expBeat);
      end
    end
    nChecks++;
    if (firstValidCycle != 3) begin
      nFails++; $display("[TB] FAIL single_first_valid: got cycle %0d expected 3", firstValidCycle);
    end
    nChecks++;
    if (doneCycle != 1 + 2 + BEATS_PER_LINE) begin
      nFails++; $display("[TB] FAIL single_done_cycle: got %0d expected %0d", doneCycle, 1 + 2 + BEATS_PER_LINE);
    end
    nChecks++;
    if (rdQ.size() != 1 || rdQ[0] !== ADDR_W'(0)) begin
      nFails++; $display("[TB] FAIL single_reads: got %0d reads expected 1 at addr 0", rdQ.size());
    end
    nChecks++;
    if (busyAtOne !== 1'b1 || busyAtDone !== 1'b0 || validAtDone !== 1'b0) begin
      nFails++; $display("[TB] FAIL single_busy: got start/done busy=%b/%b tvalid@done=%b expected 1/0 0", busyAtOne, busyAtDone, validAtDone);
    end
  endtask

  task automatic test_multi_line();
    int                       nExp;
    logic [AXIS_DATA_WIDTH:0] expBeat;
    logic [AXIS_DATA_WIDTH:0] gotBeat;
    pushExpected(4, 3);
    applyStimulus(4, 3);
    drain(0, 300);
    nExp = expQ.size();
    nChecks++;
    if (obsQ.size() != nExp) begin
      nFails++; $display("[TB] FAIL multi_beat_count: got %0d expected %0d", obsQ.size(), nExp);
    end
    for (int i = 0; i < nExp; i++) begin
      expBeat = expQ.pop_front();
      gotBeat = (i < obsQ.size()) ? obsQ[i] : 'x;
      nChecks++;
      if (gotBeat !== expBeat) begin
        nFails++; $display("[TB] FAIL multi_beat%0d: got %h expected %h", i, gotBeat, expBeat);
      end
    end
    nChecks++;
    if (gapCycles != 0) begin
      nFails++; $display("[TB] FAIL multi_tvalid_gap: got %0d idle cycles expected 0", gapCycles);
    end
    nChecks++;
    if (rdQ.size() != 3 || rdQ[0] !== ADDR_W'(4) || rdQ[1] !== ADDR_W'(5) || rdQ[2] !== ADDR_W'(6)) begin
      nFails++; $display("[TB] FAIL multi_reads: got %0d reads expected addrs 4,5,6", rdQ.size());
    end
    nChecks++;
    if (doneCycle != 1 + 2 + 3 * BEATS_PER_LINE) begin
      nFails++; $display("[TB] FAIL multi_done_cycle: got %0d expected %0d", doneCycle, 1 + 2 + 3 * BEATS_PER_LINE);
    end
  endtask

  task automatic test_backpressure();
    int                       nExp;
    logic [AXIS_DATA_WIDTH:0] expBeat;
    logic [AXIS_DATA_WIDTH:0] gotBeat;
    pushExpected(20, 2);
    applyStimulus(20, 2);
    drain(1, 400);
    nExp = expQ.size();
    nChecks++;
    if (obsQ.size() != nExp) begin
      nFails++; $display("[TB] FAIL bp_beat_count: got %0d expected %0d", obsQ.size(), nExp);
    end
    for (int i = 0; i < nExp; i++) begin
      expBeat = expQ.pop_front();
      gotBeat = (i < obsQ.size()) ? obsQ[i] : 'x;
      nChecks++;
      if (gotBeat !== expBeat) begin
        nFails++; $display("[TB] FAIL bp_beat%0d: got %h expected %h", i, gotBeat, expBeat);
      end
    end
    nChecks++;
    if (stallErrs != 0 || stallCycles < 10) begin
      nFails++; $display("[TB] FAIL bp_stall_stable: got %0d changes in %0d stalls expected 0 changes, >=10 stalls", stallErrs, stallCycles);
    end
    nChecks++;
    if (doneCycle != 1 + 2 + 2 * BEATS_PER_LINE + stallCycles) begin
      nFails++; $display("[TB] FAIL bp_done_cycle: got %0d expected %0d", doneCycle, 1 + 2 + 2 * BEATS_PER_LINE + stallCycles);
    end
  endtask

  task automatic test_address_wrap();
    int                       nExp;
    logic [AXIS_DATA_WIDTH:0] expBeat;
    logic [AXIS_DATA_WIDTH:0] gotBeat;
    pushExpected(BRAM_DEPTH - 1, 2);
    applyStimulus(BRAM_DEPTH - 1, 2);
    drain(0, 300);
    nExp = expQ.size();
    nChecks++;
    if (obsQ.size() != nExp) begin
      nFails++; $display("[TB] FAIL wrap_beat_count: got %0d expected %0d", obsQ.size(), nExp);
    end
    for (int i = 0; i < nExp; i++) begin
      expBeat = expQ.pop_front();
      gotBeat = (i < obsQ.size()) ? obsQ[i] : 'x;
      nChecks++;
      if (gotBeat !== expBeat) begin
        nFails++; $display("[TB] FAIL wrap_beat%0d: got %h expected %h", i, gotBeat, expBeat);
      end
    end
    nChecks++;
    if (rdQ.size() != 2 || rdQ[0] !== ADDR_W'(BRAM_DEPTH - 1) || rdQ[1] !== ADDR_W'(0)) begin
      nFails++; $display("[TB] FAIL wrap_reads: got %0d reads expected addrs %0d,0", rdQ.size(), BRAM_DEPTH - 1);
    end
  endtask

  task automatic test_zero_and_busy_start();
    int                       nExp;
    int                       extra;
    logic [AXIS_DATA_WIDTH:0] expBeat;
    logic [AXIS_DATA_WIDTH:0] gotBeat;
    applyStimulus(0, 0);
    drain(0, 20);
    nChecks++;
    if (doneCycle != 1 || obsQ.size() != 0 || firstValidCycle != -1 || rdQ.size() != 0 || busyAtDone !== 1'b0) begin
      nFails++; $display("[TB] FAIL zero_lines: got done@%0d beats=%0d reads=%0d expected done@1 no beats no reads", doneCycle, obsQ.size(), rdQ.size());
    end
    pushExpected(40, 1);
    applyStimulus(40, 1);
    drain(3, 200);
    nExp = expQ.size();
    nChecks++;
    if (obsQ.size() != nExp || rdQ.size() != 1) begin
      nFails++; $display("[TB] FAIL busy_start_count: got %0d beats %0d reads expected %0d beats 1 read", obsQ.size(), rdQ.size(), nExp);
    end
    for (int i = 0; i < nExp; i++) begin
      expBeat = expQ.pop_front();
      gotBeat = (i < obsQ.size()) ? obsQ[i] : 'x;
      nChecks++;
      if (gotBeat !== expBeat) begin
        nFails++; $display("[TB] FAIL busy_start_beat%0d: got %h expected %h", i, gotBeat, expBeat);
      end
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_axis_tvalid || o_mem_rd_en || o_busy) extra++;
    end
    nChecks++;
    if (extra != 0) begin
      nFails++; $display("[TB] FAIL busy_start_idle: got %0d active cycles after done expected 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int                       nExp;
    int                       active;
    bit                       found;
    logic [AXIS_DATA_WIDTH:0] expBeat;
    logic [AXIS_DATA_WIDTH:0] gotBeat;
    applyStimulus(8, 2);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      m_axis_tready = 1'b1;
      if (m_axis_tvalid && m_axis_tdata == {32'd8, 32'd5}) found = 1;
    end
    nChecks++;
    if (!found) begin
      nFails++; $display("[TB] FAIL abort_reach_beat5: got no beat 5 expected it within 100 cycles");
    end
    rst = 1'b1;
    #1;
    nChecks++;
    if ({o_busy, o_done, o_mem_rd_en, o_mem_rd_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
      nFails++; $display("[TB] FAIL abort_outputs: got busy=%b done=%b rd=%b tvalid=%b expected all 0", o_busy, o_done, o_mem_rd_en, m_axis_tvalid);
    end
    @(negedge clk);
    rst = 1'b0;
    active = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_done || m_axis_tvalid || o_busy || o_mem_rd_en) active++;
    end
    nChecks++;
    if (active != 0) begin
      nFails++; $display("[TB] FAIL abort_quiet: got %0d active cycles after reset expected 0", active);
    end
    pushExpected(8, 1);
    applyStimulus(8, 1);
    drain(0, 200);
    nExp = expQ.size();
    nChecks++;
    if (obsQ.size() != nExp || rdQ.size() != 1 || doneCycle != 1 + 2 + BEATS_PER_LINE) begin
      nFails++; $display("[TB] FAIL restart_count: got %0d beats %0d reads done@%0d expected %0d beats 1 read done@%0d", obsQ.size(), rdQ.size(), doneCycle, nExp, 1 + 2 + BEATS_PER_LINE);
    end
    for (int i = 0; i < nExp; i++) begin
      expBeat = expQ.pop_front();
      gotBeat = (i < obsQ.size()) ? obsQ[i] : 'x;
      nChecks++;
      if (gotBeat !== expBeat) begin
        nFails++; $display("[TB] FAIL restart_beat%0d: got %h expected %h", i, gotBeat, expBeat);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    i_start       = 1'b0;
    i_base_addr   = '0;
    i_num_lines   = '0;
    m_axis_tready = 1'b0;
    $display("[TB] weight_axis_streamer bench starting");
    test_reset();
    test_single_line();
    test_multi_line();
    test_backpressure();
    test_address_wrap();
    test_zero_and_busy_start();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
